// File: rtl/trace_pkg.sv
// trace_pkg: record layout, kind/error encodings and FSM states for the retirement-trace checker.
package trace_pkg;
  localparam int REC_W = 55;
  localparam int KIND_LSB = 52;
  localparam int KIND_W = 3;
  localparam int PC_LSB = 36;
  localparam int PC_W = 16;
  localparam int REG_LSB = 32;
  localparam int REG_W = 4;
  localparam int VAL_LSB = 16;
  localparam int VAL_W = 16;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W = 16;
  localparam int FM_ADDR = 0;
  localparam int FM_VAL = 1;
  localparam int FM_REG = 2;
  localparam int FM_PC = 3;
  localparam int FM_KIND = 4;
  localparam int FM_W = 5;
  typedef enum logic [2:0] {K_REG = 3'd0, K_LD = 3'd1, K_ST = 3'd2, K_HALT = 3'd3, K_OTHER = 3'd4} kind_e;
  typedef enum logic [2:0] {E_NONE = 3'd0, E_MISMATCH = 3'd1, E_UNDERRUN = 3'd2, E_OVERRUN = 3'd3} err_e;
  typedef enum logic [1:0] {S_PRIME, S_RUN, S_PASS, S_FAIL} state_e;
  function automatic kind_e classify(input logic rw, input logic mr, input logic halt, input logic mw);
    return (rw && mr) ? K_LD : rw ? K_REG : halt ? K_HALT : mw ? K_ST : K_OTHER;
  endfunction
endpackage

// File: rtl/trace_exp_buf.sv
// trace_exp_buf: 2-entry FIFO of expected trace records with simultaneous push and pop.
module trace_exp_buf
  import trace_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [REC_W-1:0] i_din,
  output logic [REC_W-1:0] o_head,
  output logic [1:0]       o_occ
);
  logic [REC_W-1:0] r_mem [2];
  logic             r_rd;
  logic             r_wr;
  logic [1:0]       r_occ;
  logic             w_pop;
  logic             w_push;
  assign w_pop  = i_pop && r_occ != 2'd0;
  assign w_push = i_push && (r_occ != 2'd2 || w_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      r_rd  <= r_rd ^ w_pop;
      r_wr  <= r_wr ^ w_push;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
  assign o_head = r_mem[r_rd];
  assign o_occ  = r_occ;
endmodule

// File: rtl/trace_checker.sv
// trace_checker: compares the cpu retirement stream against an expected trace read from a synchronous ROM.
module trace_checker
  import trace_pkg::*;
#(
  parameter int TRACE_AW = 10,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                evt_valid,
  input  logic [15:0]         evt_pc,
  input  logic                evt_reg_write,
  input  logic [3:0]          evt_wreg,
  input  logic [15:0]         evt_wdata,
  input  logic                evt_mem_read,
  input  logic                evt_mem_write,
  input  logic [15:0]         evt_mem_addr,
  input  logic [15:0]         evt_mem_data,
  input  logic                evt_halt,
  output logic                exp_rd_en,
  output logic [TRACE_AW-1:0] exp_rd_addr,
  input  logic [REC_W-1:0]    exp_rd_data,
  output logic                done,
  output logic                pass,
  output logic [2:0]          err_code,
  output logic [FM_W-1:0]     fail_mask,
  output logic [CNT_W-1:0]    fail_inum,
  output logic [CNT_W-1:0]    inst_count
);
  localparam logic [TRACE_AW:0] IDX_TOP = {1'b1, {TRACE_AW{1'b0}}};
  state_e            r_state;
  state_e            w_next;
  logic [TRACE_AW:0] r_idx;
  logic              r_inflight;
  logic              r_done;
  logic              r_pass;
  logic [2:0]        r_err;
  logic [FM_W-1:0]   r_mask;
  logic [CNT_W-1:0]  r_inum;
  logic [CNT_W-1:0]  r_count;
  logic [REC_W-1:0]  w_head;
  logic [1:0]        w_occ;
  logic              w_active;
  logic              w_empty;
  logic              w_exhausted;
  logic              w_ready;
  logic              w_pop;
  logic              w_issue;
  kind_e             w_ekind;
  logic              w_rw_kind;
  logic              w_mem_kind;
  logic [FM_W-1:0]   w_mask;
  err_e              w_err;
  trace_exp_buf u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_inflight),
    .i_pop  (w_pop),
    .i_din  (exp_rd_data),
    .o_head (w_head),
    .o_occ  (w_occ)
  );
  assign w_active    = r_state == S_PRIME || r_state == S_RUN;
  assign w_empty     = w_occ == 2'd0;
  assign w_exhausted = r_idx == IDX_TOP && !r_inflight;
  assign w_ready     = w_occ == 2'd2 || (w_occ == 2'd1 && w_exhausted);
  assign w_pop       = w_active && evt_valid && !w_empty;
  // The entry popped this cycle frees a slot, so a read can be issued in the same cycle.
  assign w_issue     = rst_n && w_active && r_idx != IDX_TOP &&
                       ({1'b0, w_occ} + {2'b0, r_inflight}) < ({2'b0, w_pop} + 3'd2);
  assign w_ekind     = classify(evt_reg_write, evt_mem_read, evt_halt, evt_mem_write);
  assign w_rw_kind   = w_ekind == K_REG || w_ekind == K_LD;
  assign w_mem_kind  = w_ekind == K_LD || w_ekind == K_ST;
  assign w_mask[FM_KIND] = w_head[KIND_LSB +: KIND_W] != w_ekind;
  assign w_mask[FM_PC]   = w_head[PC_LSB +: PC_W] != evt_pc;
  assign w_mask[FM_REG]  = w_rw_kind && w_head[REG_LSB +: REG_W] != evt_wreg;
  assign w_mask[FM_VAL]  = (w_rw_kind || w_ekind == K_ST) &&
                           w_head[VAL_LSB +: VAL_W] != (w_ekind == K_ST ? evt_mem_data : evt_wdata);
  assign w_mask[FM_ADDR] = w_mem_kind && w_head[ADDR_LSB +: ADDR_W] != evt_mem_addr;
  always_comb begin
    w_next = r_state;
    w_err  = E_NONE;
    if (w_active && evt_valid) begin
      if (w_empty) begin
        w_next = S_FAIL;
        w_err  = (r_state == S_RUN && w_exhausted) ? E_OVERRUN : E_UNDERRUN;
      end else if (w_mask != '0) begin
        w_next = S_FAIL;
        w_err  = E_MISMATCH;
      end else if (w_ekind == K_HALT) w_next = S_PASS;
      else if (r_state == S_PRIME && w_ready) w_next = S_RUN;
    end else if (r_state == S_PRIME && w_ready) w_next = S_RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_PRIME;
      r_idx      <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= E_NONE;
      r_mask     <= '0;
      r_inum     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_issue) r_idx <= r_idx + 1'b1;
      if (w_pop && w_mask == '0) r_count <= r_count + 1'b1;
      if (w_active && w_next == S_FAIL) begin
        r_done <= 1'b1;
        r_err  <= w_err;
        r_mask <= w_empty ? '0 : w_mask;
        r_inum <= r_count;
      end
      if (w_active && w_next == S_PASS) begin
        r_done <= 1'b1;
        r_pass <= 1'b1;
      end
    end
  end
  assign exp_rd_en   = w_issue;
  assign exp_rd_addr = r_idx[TRACE_AW-1:0];
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_code    = r_err;
  assign fail_mask   = r_mask;
  assign fail_inum   = r_inum;
  assign inst_count  = r_count;
endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: randomized and directed checking of trace_checker against a trace-level reference model.
module tb_trace_checker;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          evt_valid = 1'b0;
  logic [15:0]   evt_pc = '0;
  logic          evt_reg_write = 1'b0;
  logic [3:0]    evt_wreg = '0;
  logic [15:0]   evt_wdata = '0;
  logic          evt_mem_read = 1'b0;
  logic          evt_mem_write = 1'b0;
  logic [15:0]   evt_mem_addr = '0;
  logic [15:0]   evt_mem_data = '0;
  logic          evt_halt = 1'b0;
  logic          exp_rd_en;
  logic [AW-1:0] exp_rd_addr;
  logic [54:0]   exp_rd_data = '0;
  logic          done;
  logic          pass;
  logic [2:0]    err_code;
  logic [4:0]    fail_mask;
  logic [15:0]   fail_inum;
  logic [15:0]   inst_count;
  logic [54:0]   rom [DEPTH];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            chk = 1'b1;
  trace_checker #(.TRACE_AW(AW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_pc(evt_pc),
    .evt_reg_write(evt_reg_write), .evt_wreg(evt_wreg), .evt_wdata(evt_wdata),
    .evt_mem_read(evt_mem_read), .evt_mem_write(evt_mem_write),
    .evt_mem_addr(evt_mem_addr), .evt_mem_data(evt_mem_data), .evt_halt(evt_halt),
    .exp_rd_en(exp_rd_en), .exp_rd_addr(exp_rd_addr), .exp_rd_data(exp_rd_data),
    .done(done), .pass(pass), .err_code(err_code), .fail_mask(fail_mask),
    .fail_inum(fail_inum), .inst_count(inst_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (exp_rd_en) exp_rd_data <= rom[exp_rd_addr];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [2:0] ev_kind(input logic rw, input logic mr, input logic hl, input logic mw);
    if (rw && mr) return 3'd1;
    if (rw) return 3'd0;
    if (hl) return 3'd3;
    if (mw) return 3'd2;
    return 3'd4;
  endfunction
  // Which fields of the expected record disagree with the current event.
  function automatic logic [4:0] bad_fields(input logic [54:0] r);
    logic [2:0]  k;
    logic [4:0]  m;
    k = ev_kind(evt_reg_write, evt_mem_read, evt_halt, evt_mem_write);
    m = '0;
    m[4] = r[54:52] != k;
    m[3] = r[51:36] != evt_pc;
    if (k == 3'd0 || k == 3'd1) m[2] = r[35:32] != evt_wreg;
    if (k == 3'd0 || k == 3'd1) m[1] = r[31:16] != evt_wdata;
    if (k == 3'd2) m[1] = r[31:16] != evt_mem_data;
    if (k == 3'd1 || k == 3'd2) m[0] = r[15:0] != evt_mem_addr;
    return m;
  endfunction
  logic        m_done, m_pass;
  logic [2:0]  m_err;
  logic [4:0]  m_mask;
  int          m_inum, m_count, m_k, m_issued;
  logic [4:0]  w_mm;
  assign w_mm = bad_fields(rom[m_k % DEPTH]);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0; m_pass <= 1'b0; m_err <= '0; m_mask <= '0;
      m_inum <= 0; m_count <= 0; m_k <= 0; m_issued <= 0;
    end else begin
      if (exp_rd_en) m_issued <= m_issued + 1;
      if (evt_valid && !m_done) begin
        if (m_k >= DEPTH) begin
          m_done <= 1'b1; m_err <= 3'd3; m_inum <= m_count;
        end else begin
          m_k <= m_k + 1;
          if (w_mm != '0) begin
            m_done <= 1'b1; m_err <= 3'd1; m_mask <= w_mm; m_inum <= m_count;
          end else begin
            m_count <= m_count + 1;
            if (rom[m_k % DEPTH][54:52] == 3'd3) begin
              m_done <= 1'b1; m_pass <= 1'b1;
            end
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk) begin
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_pass));
      check("err_code", 32'(err_code), 32'(m_err));
      check("fail_mask", 32'(fail_mask), 32'(m_mask));
      check("fail_inum", 32'(fail_inum), 32'(m_inum));
      check("inst_count", 32'(inst_count), 32'(m_count));
      check("outstanding_le2", 32'(m_issued - m_k <= 2), 32'd1);
      if (!rst_n || m_done) check("rd_en_idle", 32'(exp_rd_en), 32'd0);
      if (exp_rd_en) check("rd_addr", 32'(exp_rd_addr), 32'(m_issued));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    evt_valid = 1'b0; evt_reg_write = 1'b0; evt_mem_read = 1'b0;
    evt_mem_write = 1'b0; evt_halt = 1'b0;
  endtask
  task automatic drive_match(input logic [54:0] r);
    evt_valid = 1'b1;
    evt_pc = r[51:36];
    evt_wreg = 4'($urandom);
    evt_wdata = 16'($urandom);
    evt_mem_addr = 16'($urandom);
    evt_mem_data = 16'($urandom);
    evt_reg_write = 1'b0; evt_halt = 1'b0;
    evt_mem_read = 1'($urandom); evt_mem_write = 1'($urandom);
    case (r[54:52])
      3'd0: begin evt_reg_write = 1'b1; evt_mem_read = 1'b0; evt_halt = 1'($urandom);
                  evt_wreg = r[35:32]; evt_wdata = r[31:16]; end
      3'd1: begin evt_reg_write = 1'b1; evt_mem_read = 1'b1; evt_halt = 1'($urandom);
                  evt_wreg = r[35:32]; evt_wdata = r[31:16]; evt_mem_addr = r[15:0]; end
      3'd2: begin evt_mem_write = 1'b1; evt_mem_addr = r[15:0]; evt_mem_data = r[31:16]; end
      3'd3: evt_halt = 1'b1;
      default: evt_mem_write = 1'b0;
    endcase
  endtask
  task automatic perturb();
    case ($urandom_range(0, 5))
      0: evt_pc = evt_pc ^ (16'd1 << $urandom_range(0, 15));
      1: evt_wreg = evt_wreg ^ (4'd1 << $urandom_range(0, 3));
      2: evt_wdata = evt_wdata ^ (16'd1 << $urandom_range(0, 15));
      3: evt_mem_addr = evt_mem_addr ^ (16'd1 << $urandom_range(0, 15));
      4: evt_mem_data = evt_mem_data ^ (16'd1 << $urandom_range(0, 15));
      default: evt_reg_write = ~evt_reg_write;
    endcase
  endtask
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic run_events(input int n);
    for (int i = 0; i < n; i++) begin
      drive_match(rom[i]);
      step();
    end
    idle();
    step();
  endtask
  function automatic logic [54:0] mk(input logic [2:0] k, input logic [15:0] pc, input logic [3:0] rg,
                                     input logic [15:0] v, input logic [15:0] a);
    return {k, pc, rg, v, a};
  endfunction
  initial begin
    // Matching three-record trace.
    rom[0] = mk(3'd0, 16'h0000, 4'd1, 16'h0005, 16'h0000);
    rom[1] = mk(3'd2, 16'h0002, 4'd0, 16'h0005, 16'h0010);
    rom[2] = mk(3'd3, 16'h0004, 4'd0, 16'h0000, 16'h0000);
    do_reset();
    check("reset_done", 32'(done), 32'd0);
    check("reset_count", 32'(inst_count), 32'd0);
    repeat (6) step();
    run_events(3);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err_code), 32'd0);
    check("t1_count", 32'(inst_count), 32'd3);
    // First event carries a wrong write value.
    do_reset();
    repeat (6) step();
    drive_match(rom[0]);
    evt_wdata = 16'h0006;
    step();
    drive_match(rom[1]);
    step();
    idle();
    step();
    check("t2_done", 32'(done), 32'd1);
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_err", 32'(err_code), 32'd1);
    check("t2_mask", 32'(fail_mask), 32'b00010);
    check("t2_inum", 32'(fail_inum), 32'd0);
    check("t2_count", 32'(inst_count), 32'd0);
    // Expected LD, event is a plain register write.
    rom[0] = mk(3'd1, 16'h0000, 4'd2, 16'h1234, 16'h0020);
    do_reset();
    repeat (6) step();
    idle();
    evt_valid = 1'b1; evt_reg_write = 1'b1; evt_pc = 16'h0000; evt_wreg = 4'd2; evt_wdata = 16'h1234;
    step();
    idle();
    step();
    check("t5_err", 32'(err_code), 32'd1);
    check("t5_kind_bit", 32'(fail_mask[4]), 32'd1);
    // Back-to-back throughput, then a reset partway through.
    for (int i = 0; i < 8; i++) rom[i] = mk(3'd4, 16'(2 * i), 4'd0, 16'h0, 16'h0);
    rom[8] = mk(3'd3, 16'h0010, 4'd0, 16'h0, 16'h0);
    do_reset();
    repeat (6) step();
    run_events(9);
    check("t3_pass", 32'(pass), 32'd1);
    check("t3_count", 32'(inst_count), 32'd9);
    do_reset();
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      drive_match(rom[i]);
      step();
    end
    idle();
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(inst_count), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_rd_en", 32'(exp_rd_en), 32'd0);
    check("t6_rst_addr", 32'(exp_rd_addr), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    run_events(9);
    check("t6_pass", 32'(pass), 32'd1);
    check("t6_count", 32'(inst_count), 32'd9);
    // Event on the very first cycle after reset release.
    chk = 1'b0;
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_match(rom[0]);
    step();
    idle();
    step();
    check("t4_err", 32'(err_code), 32'd2);
    check("t4_inum", 32'(fail_inum), 32'd0);
    check("t4_done", 32'(done), 32'd1);
    do_reset();
    chk = 1'b1;
    // Trace exhausted without a halt.
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(3'd4, 16'(i), 4'd0, 16'h0, 16'h0);
    do_reset();
    repeat (6) step();
    for (int i = 0; i < DEPTH; i++) begin
      drive_match(rom[i]);
      step();
    end
    drive_match(mk(3'd4, 16'h0099, 4'd0, 16'h0, 16'h0));
    step();
    idle();
    step();
    check("t7_err", 32'(err_code), 32'd3);
    check("t7_inum", 32'(fail_inum), 32'd16);
    check("t7_count", 32'(inst_count), 32'd16);
    // Random traces with occasional corrupted events and idle gaps.
    for (int run = 0; run < 25; run++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [2:0] k;
        k = ($urandom_range(0, 24) == 0) ? 3'(5 + $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
        rom[i] = mk(k, 16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
      end
      do_reset();
      repeat (6) step();
      for (int e = 0; e < 20 && !m_done; e++) begin
        drive_match(rom[e % DEPTH]);
        if ($urandom_range(0, 9) == 0) perturb();
        step();
        idle();
        repeat ($urandom_range(0, 2)) step();
      end
      idle();
      repeat (3) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Synthesizable retirement-trace checker. Reads an expected trace of per-instruction records from an external synchronous ROM and compares it with the live retirement stream of the single-cycle cpu.
- Record classes match the simulation trace format: reg write, load, store, halt, and other (branch/NOP).
- Sits beside cpu in FPGA/emulation builds. Reports pass/fail, the first failing instruction number and the mismatching fields.

Parameters:
- TRACE_AW, 10, expected-ROM address width (depth 2^TRACE_AW records).
- CNT_W, 16, width of the instruction counter and fail_inum.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- evt_valid  in  1  one instruction retired this cycle.
- evt_pc  in  16  PC of the retiring instruction.
- evt_reg_write  in  1  register file written.
- evt_wreg  in  4  destination register.
- evt_wdata  in  16  register write data.
- evt_mem_read  in  1  instruction reads data memory.
- evt_mem_write  in  1  data memory written.
- evt_mem_addr  in  16  data memory address.
- evt_mem_data  in  16  store data.
- evt_halt  in  1  halt retiring.
- exp_rd_en  out  1  ROM read strobe.
- exp_rd_addr  out  TRACE_AW  ROM record index.
- exp_rd_data  in  55  record {kind[54:52], pc[51:36], reg[35:32], value[31:16], addr[15:0]}; valid exactly 1 cycle after exp_rd_en.
- done  out  1  checking finished (sticky).
- pass  out  1  halt matched with no error (sticky).
- err_code  out  3  0 NONE, 1 MISMATCH, 2 UNDERRUN, 3 OVERRUN.
- fail_mask  out  5  mismatching fields {kind, pc, reg, value, addr}.
- fail_inum  out  CNT_W  index of the failing event.
- inst_count  out  CNT_W  events consumed.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0.
  - Prefetch buffer is emptied, in-flight read is cancelled, read index is 0, FSM goes to PRIME.
- Event classification, priority order:
  - reg_write & mem_read -> LD(1)
  - reg_write -> REG(0)
  - halt -> HALT(3)
  - mem_write -> ST(2)
  - otherwise -> OTHER(4)
- Fields compared per kind (kind and pc are always compared):
  - REG: reg, value = wdata.
  - LD: reg, value, addr.
  - ST: addr, value = mem_data.
  - HALT, OTHER: no further fields.
- Prefetch:
  - 2-entry expected buffer.
  - Issue exp_rd_en whenever (occupancy + in-flight reads) < 2 and read index < 2^TRACE_AW, accounting for the entry popped this cycle.
  - Read index increments on each issue and saturates at the top; it never wraps.
  - Sustains one compare per cycle indefinitely.
- FSM states and transitions:
  - PRIME: waits for the buffer to reach 2 entries, then goes to RUN. A 1-entry buffer is accepted only when the ROM is exhausted.
    - An evt_valid with an empty buffer goes to FAIL, err UNDERRUN.
    - An evt_valid with a nonempty buffer is compared normally.
  - RUN: each evt_valid pops the head entry, compares it and increments inst_count.
    - Any field mismatch goes to FAIL, err MISMATCH; latch fail_mask and fail_inum = inst_count before the increment.
    - Matched HALT goes to PASS.
    - evt_valid with an empty buffer and the ROM exhausted goes to FAIL, err OVERRUN.
  - PASS / FAIL: terminal. done=1; pass=1 only in PASS; exp_rd_en=0.
    - Further events are ignored and inst_count freezes.
    - Exit only via reset.
- Latency: done/pass/err_code/fail_* update on the clock edge that consumes the offending or halting event, and are visible the next cycle.
- Corner cases:
  - Simultaneous pop and ROM return into a full buffer cannot occur, because the issue rule reserves a slot.
  - Reset mid-run discards the in-flight ROM data; the cycle after rst_n rises restarts at index 0.
  - An expected kind value >4 is always a kind mismatch.

Decomposition:
- Package trace_pkg:
  - kind encodings REG/LD/ST/HALT/OTHER.
  - err_code encodings.
  - record field offsets and widths (55-bit record).
  - fail_mask bit positions.
- One sub-module, trace_exp_buf: 2-entry FIFO of 55-bit records with push/pop, occupancy, and simultaneous push+pop.
- Classifier and comparator stay combinational inside trace_checker.

Test Plan:
- Matching trace (ROM: REG pc 0x0000 r1 0x0005; ST pc 0x0002 addr 0x0010 val 0x0005; HALT pc 0x0004) with 3 back-to-back events after PRIME -> pass=1, done=1, err_code=0, inst_count=3.
- Same ROM, first event wdata=0x0006 -> done=1, pass=0, err_code=1, fail_mask=value bit only, fail_inum=0, inst_count frozen at 0.
- Throughput: 8 consecutive matching OTHER events then HALT, evt_valid held high 9 cycles -> no UNDERRUN, pass=1, inst_count=9, at most 2 reads outstanding or buffered at any time.
- evt_valid asserted on the first cycle after rst_n rises -> err_code=2 (UNDERRUN), fail_inum=0.
- Expected LD r2 0x1234 addr 0x0020; event reg_write=1, mem_read=0 -> err_code=1, fail_mask has the kind bit set.
- rst_n pulsed low mid-run after 3 events -> all outputs 0 immediately; the rerun re-reads index 0 and passes the full trace.
